// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 4-digit seven-segment scanner.
// Holds the scan FSM encoding, idle output patterns and small digit-select helpers.
package seg_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } scan_state_e;

   localparam logic [6:0] SEG_BLANK  = 7'b1111111;
   localparam logic [3:0] AN_ALL_OFF = 4'b1111;

   // Active-low anode pattern with only the selected digit enabled.
   function automatic logic [3:0] an_select(input logic [1:0] digit);
      logic [3:0] an;
      case (digit)
         2'd0:    an = 4'b1110;
         2'd1:    an = 4'b1101;
         2'd2:    an = 4'b1011;
         2'd3:    an = 4'b0111;
         default: an = AN_ALL_OFF;
      endcase
      return an;
   endfunction

   function automatic logic [3:0] nibble_select(input logic [15:0] value,
                                                input logic [1:0]  digit);
      logic [3:0] nib;
      case (digit)
         2'd0:    nib = value[3:0];
         2'd1:    nib = value[7:4];
         2'd2:    nib = value[11:8];
         2'd3:    nib = value[15:12];
         default: nib = 4'h0;
      endcase
      return nib;
   endfunction

   // True when this digit and every more-significant digit are zero; digit 0 never qualifies.
   function automatic logic leading_zero(input logic [15:0] value,
                                         input logic [1:0]  digit);
      logic lz;
      case (digit)
         2'd0:    lz = 1'b0;
         2'd1:    lz = (value[15:4]  == 12'h000);
         2'd2:    lz = (value[15:8]  == 8'h00);
         2'd3:    lz = (value[15:12] == 4'h0);
         default: lz = 1'b0;
      endcase
      return lz;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_binary_to_segment.sv
// Combinational hex nibble to active-low seven-segment decoder (bit 6 = a, bit 0 = g).
module binary_to_segment
   import seg_scan_ctrl_pkg::*;
(
   input  logic [3:0] bin_i,
   output logic [6:0] seg_o
);

   // Hex glyph lookup.
   always_comb begin
      seg_o = SEG_BLANK;
      case (bin_i)
         4'h0:    seg_o = 7'b0000001;
         4'h1:    seg_o = 7'b1001111;
         4'h2:    seg_o = 7'b0010010;
         4'h3:    seg_o = 7'b0000110;
         4'h4:    seg_o = 7'b1001100;
         4'h5:    seg_o = 7'b0100100;
         4'h6:    seg_o = 7'b0100000;
         4'h7:    seg_o = 7'b0001111;
         4'h8:    seg_o = 7'b0000000;
         4'h9:    seg_o = 7'b0000100;
         4'hA:    seg_o = 7'b0001000;
         4'hB:    seg_o = 7'b1100000;
         4'hC:    seg_o = 7'b0110001;
         4'hD:    seg_o = 7'b1000010;
         4'hE:    seg_o = 7'b0110000;
         4'hF:    seg_o = 7'b0111000;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with anti-ghosting gaps,
// a one-deep update handshake committed only at frame boundaries, and leading-zero blanking.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int DRIVE_CYC = 50000,
   parameter int GAP_CYC   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        upd_valid,
   input  logic [15:0] upd_value,
   input  logic [3:0]  upd_dp,
   input  logic        lz_blank,
   output logic        upd_ready,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int CNT_MAX = (DRIVE_CYC > GAP_CYC) ? DRIVE_CYC : GAP_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

   scan_state_e      state_q, state_d;
   logic [1:0]       digit_q, digit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             pending_q, pending_d;
   logic [15:0]      pend_val_q, pend_val_d;
   logic [3:0]       pend_dp_q, pend_dp_d;
   logic [15:0]      disp_val_q, disp_val_d;
   logic [3:0]       disp_dp_q, disp_dp_d;

   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             frame_tick_q, frame_tick_d;

   logic             frame_end_s;
   logic             commit_s;
   logic             capture_s;
   logic [3:0]       nibble_s;
   logic [6:0]       dec_seg_s;
   logic             blank_s;

   // Scan sequencing: OFF -> DRIVE -> GAP -> DRIVE(next digit); en low always parks in OFF.
   always_comb begin
      state_d     = state_q;
      digit_d     = digit_q;
      cnt_d       = cnt_q;
      frame_end_s = 1'b0;
      if (!en) begin
         state_d = ST_OFF;
         digit_d = 2'd0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_DRIVE;
               digit_d = 2'd0;
               cnt_d   = '0;
            end
            ST_DRIVE: begin
               if (cnt_q == DRIVE_LAST) begin
                  state_d = ST_GAP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_d     = ST_DRIVE;
                  digit_d     = digit_q + 2'd1;
                  cnt_d       = '0;
                  frame_end_s = (digit_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_OFF;
               digit_d = 2'd0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Update handshake; capture needs !pending and commit needs pending, so they never coincide.
   always_comb begin
      capture_s  = upd_valid && !pending_q;
      commit_s   = pending_q && ((state_q == ST_OFF) || frame_end_s);
      pending_d  = pending_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      if (capture_s) begin
         pending_d  = 1'b1;
         pend_val_d = upd_value;
         pend_dp_d  = upd_dp;
      end else if (commit_s) begin
         pending_d  = 1'b0;
         disp_val_d = pend_val_q;
         disp_dp_d  = pend_dp_q;
      end else begin
         pending_d  = pending_q;
      end
      frame_tick_d = commit_s;
   end

   assign nibble_s = nibble_select(disp_val_q, digit_q);

   binary_to_segment u_dec (
      .bin_i (nibble_s),
      .seg_o (dec_seg_s)
   );

   // Output pattern for the current state/digit, registered one clock later.
   always_comb begin
      an_d    = AN_ALL_OFF;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;
      blank_s = lz_blank && leading_zero(disp_val_q, digit_q);
      if (state_q == ST_DRIVE) begin
         an_d  = an_select(digit_q);
         seg_d = blank_s ? SEG_BLANK : dec_seg_s;
         dp_d  = ~disp_dp_q[digit_q];
      end else begin
         an_d  = AN_ALL_OFF;
         seg_d = SEG_BLANK;
         dp_d  = 1'b1;
      end
   end

   // State, handshake and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_OFF;
         digit_q      <= 2'd0;
         cnt_q        <= '0;
         pending_q    <= 1'b0;
         pend_val_q   <= 16'h0000;
         pend_dp_q    <= 4'b0000;
         disp_val_q   <= 16'h0000;
         disp_dp_q    <= 4'b0000;
         an_q         <= AN_ALL_OFF;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         digit_q      <= digit_d;
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign upd_ready  = ~pending_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed plus randomized bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

   localparam int D     = 4;
   localparam int G     = 2;
   localparam int SLOT  = D + G;
   localparam int FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        upd_valid = 1'b0;
   logic [15:0] upd_value = 16'h0000;
   logic [3:0]  upd_dp = 4'h0;
   logic        lz_blank = 1'b0;
   logic        upd_ready;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   seg_scan_ctrl #(.DRIVE_CYC(D), .GAP_CYC(G)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .upd_valid  (upd_valid),
      .upd_value  (upd_value),
      .upd_dp     (upd_dp),
      .lz_blank   (lz_blank),
      .upd_ready  (upd_ready),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   logic [6:0] hex_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // Reference model: on/position-in-frame plus the pending and displayed values.
   bit          m_on;
   int          m_pos;
   bit          m_pend;
   logic [15:0] m_pval, m_dval;
   logic [3:0]  m_pdp, m_ddp;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp, e_tick;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_on = 1'b0; m_pos = 0; m_pend = 1'b0;
      m_pval = 16'h0; m_dval = 16'h0; m_pdp = 4'h0; m_ddp = 4'h0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
   endtask

   task automatic model_step();
      int d;
      bit drv, commit, blanked;
      logic [3:0] sel;
      d   = m_pos / SLOT;
      drv = m_on && ((m_pos % SLOT) < D);
      if (drv) begin
         sel     = 4'b0001;
         sel     = sel << d;
         e_an    = ~sel;
         blanked = lz_blank && (d >= 1) && ((m_dval >> (4 * d)) == 16'h0);
         e_seg   = blanked ? 7'h7F : hex_tab[m_dval[4*d +: 4]];
         e_dp    = ~m_ddp[d];
      end else begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      commit = m_pend && (!m_on || (en && (m_pos == FRAME - 1)));
      e_tick = commit;
      if (upd_valid && !m_pend) begin
         m_pend = 1'b1; m_pval = upd_value; m_pdp = upd_dp;
      end else if (commit) begin
         m_pend = 1'b0; m_dval = m_pval; m_ddp = m_pdp;
      end
      if (!en) begin
         m_on = 1'b0; m_pos = 0;
      end else if (!m_on) begin
         m_on = 1'b1; m_pos = 0;
      end else begin
         m_pos = (m_pos + 1) % FRAME;
      end
   endtask

   task automatic check_all();
      check("an", {12'h0, an}, {12'h0, e_an});
      check("seg", {9'h0, seg}, {9'h0, e_seg});
      check("dp", {15'h0, dp}, {15'h0, e_dp});
      check("frame_tick", {15'h0, frame_tick}, {15'h0, e_tick});
      check("upd_ready", {15'h0, upd_ready}, {15'h0, !m_pend});
   endtask

   // Called at a negedge with inputs already set for the coming edge.
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_to_pos(input int p);
      for (int i = 0; i < 2 * FRAME && !(m_on && m_pos == p); i++) tick();
   endtask

   // Asserts reset between clock edges and checks outputs before any edge arrives.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_an", {12'h0, an}, 16'h000F);
      check("rst_seg", {9'h0, seg}, 16'h007F);
      check("rst_dp", {15'h0, dp}, 16'h0001);
      check("rst_ready", {15'h0, upd_ready}, 16'h0001);
      check("rst_tick", {15'h0, frame_tick}, 16'h0000);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      check("por_an", {12'h0, an}, 16'h000F);
      check("por_seg", {9'h0, seg}, 16'h007F);
      check("por_ready", {15'h0, upd_ready}, 16'h0001);
      rst_n = 1'b1;

      // Free-running scan with nothing committed.
      en = 1'b1;
      run(2 * FRAME);

      // Update while dark: commit happens one clock after capture.
      en = 1'b0;
      run(2);
      upd_value = 16'h0158; upd_dp = 4'h0; upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0;
      run(3);
      en = 1'b1;
      run(2 * FRAME);

      // Mid-frame update waits for the frame boundary; a second offer is ignored.
      run_to_pos(8);
      upd_value = 16'h0005; upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0;
      run(3);
      upd_value = 16'hFFFF; upd_dp = 4'hF; upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0; upd_dp = 4'h0;
      run(2 * FRAME);

      // Leading-zero blanking with a decimal point on a blanked digit.
      lz_blank = 1'b1;
      upd_value = 16'h0005; upd_dp = 4'b0100; upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0;
      run(3 * FRAME);

      // Reset during DRIVE of digit 2 with an update pending.
      run_to_pos(1);
      upd_value = 16'hABCD; upd_dp = 4'hA; upd_valid = 1'b1;
      tick();
      upd_valid = 1'b0;
      run_to_pos(2 * SLOT + 1);
      async_reset();
      run(2 * FRAME);

      // Enable dropped during the gap after digit 1, then resumed.
      run_to_pos(SLOT + D);
      en = 1'b0;
      run(3);
      en = 1'b1;
      run(FRAME + 3);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         en        = ($urandom_range(0, 39) != 0);
         upd_valid = ($urandom_range(0, 5) == 0);
         upd_value = 16'($urandom);
         if ($urandom_range(0, 2) == 0) upd_value[15:8] = 8'h00;
         upd_dp    = 4'($urandom);
         if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DRIVE_CYC, default 50000: clocks each digit is driven.
REQ-002 SHALL have parameter GAP_CYC, default 16: clocks all anodes are off between digits (anti-ghosting); legal range >=1.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: scan enable; 0 = display dark.
REQ-006 SHALL have port upd_valid, input, 1: new display value offered.
REQ-007 SHALL have port upd_value, input, 16: four hex nibbles; [3:0] = digit 0 (rightmost).
REQ-008 SHALL have port upd_dp, input, 4: decimal-point enables, bit k = digit k, 1 = lit.
REQ-009 SHALL have port lz_blank, input, 1: leading-zero blanking enable.
REQ-010 SHALL have port upd_ready, output, 1: high when no update is pending.
REQ-011 SHALL have port an, output, 4: active-low anodes, bit k = digit k.
REQ-012 SHALL have port seg, output, 7: active-low segments, MSB = a, LSB = g.
REQ-013 SHALL have port dp, output, 1: active-low decimal point.
REQ-014 SHALL have port frame_tick, output, 1: one-cycle pulse on each committed update.

Function
REQ-015 FSM states SHALL be OFF, DRIVE, GAP, with a 2-bit digit index and a cycle counter.
REQ-016 Transitions: OFF->DRIVE(digit 0) when en=1; DRIVE->GAP after DRIVE_CYC clocks; GAP->DRIVE(digit+1 mod 4) after GAP_CYC clocks; any state->OFF when en=0, digit index cleared to 0.
REQ-017 In DRIVE for digit k, an SHALL have only bit k low; in OFF and GAP, an=4'b1111, seg=7'b1111111, dp=1.
REQ-018 an, seg, dp SHALL be registered; they SHALL reflect FSM state/digit with exactly 1 clock latency.
REQ-019 seg SHALL be the active-low hex pattern of the displayed nibble (0->0000001, 1->1001111, 5->0100100, 8->0000000).
REQ-020 dp SHALL be low only in DRIVE for digit k with committed dp bit k = 1.
REQ-021 With lz_blank=1, digit k>=1 SHALL be blanked (seg=1111111) when committed nibbles k..3 are all zero; digit 0 is never blanked; dp is unaffected by blanking.
REQ-022 Handshake: upd_ready = !pending; upd_valid & upd_ready captures value and dp into a pending register and sets pending.
REQ-023 Commit (pending -> displayed registers, pending cleared, frame_tick=1) SHALL occur only on GAP(digit 3)->DRIVE(digit 0), or on the first clock pending is set while in OFF.
REQ-024 A capture and a commit SHALL never occur in the same cycle; a value captured at a boundary commits at the next boundary.
REQ-025 upd_valid while upd_ready=0 SHALL be ignored; offered data is not queued.
REQ-026 lz_blank is sampled live, not via the pending register.

Reset
REQ-027 Assertion of rst_n=0 SHALL immediately force: state OFF, digit 0, counter 0, displayed value 0, dp bits 0, pending 0, an=4'b1111, seg=7'b1111111, dp=1, upd_ready=1, frame_tick=0.
REQ-028 Reset mid-frame or mid-handshake SHALL discard any pending update; scanning restarts from digit 0 after release with en=1.

Structure
REQ-029 The shared package SHALL hold the FSM state enumeration and the blank-segment constant 7'b1111111.
REQ-030 The single sub-module SHALL be the team's existing combinational binary_to_segment decoder, instanced once on the selected nibble.
REQ-031 Counter width SHALL be sized from max(DRIVE_CYC, GAP_CYC); no other sub-modules.

Verification (DRIVE_CYC=4, GAP_CYC=2, frame = 24 clocks)
REQ-032 Reset, en=1, no update -> an cycles 1110,1111,1101,1111,1011,1111,0111,1111 with 4/2-clock dwell; seg=0000001 on every driven digit.
REQ-033 en=0, upd_value=16'h0158, valid -> ready drops 1 clock, frame_tick pulses next clock; after en=1 digits 0..3 show 0000000, 0100100, 1001111, 0000001.
REQ-034 en=1, update 16'h0005 mid-frame -> digit 0 keeps old pattern until the GAP(3)->DRIVE(0) boundary; frame_tick pulses there; upd_ready low until then; second valid in between ignored.
REQ-035 lz_blank=1, value 16'h0005, upd_dp=4'b0100 -> digits 3 blank, 2 blank with dp=0, 1 blank, 0 shows 0100100.
REQ-036 rst_n low mid-DRIVE(digit 2) with pending set -> an=1111, upd_ready=1 without waiting for a clock edge; prior pending value never displayed.
REQ-037 en dropped during GAP(digit 1) -> next clock OFF; re-enable resumes at digit 0.
